exe_trace_streamer: RTL and testbench
=====================================

Name: exe_trace_streamer

Overview:
Downstream of the execution unit. On every cycle where the execution unit asserts exe_enable, this block captures one PC/IR pair into an internal FIFO. It then streams each captured pair as a framed byte record over a valid/ready interface toward the UART TX path. The host side rebuilds the same PC/IR trace that the simulation comparator checks, which lets us compare silicon against the golden vector file.

Parameters:
FIFO_ADDR_BITS, 4, log2 of FIFO depth; depth = 2^FIFO_ADDR_BITS records (16 by default).
SYNC_BYTE, 8'hA5, first byte of every record.

Ports:
clk  input  1  system clock, 100 MHz domain of the core.
reset  input  1  asynchronous, active-high reset.
exe_enable  input  1  execution-unit strobe; one retired instruction per high cycle.
PC_in  input  32  PC of the instruction qualified by exe_enable.
IR_in  input  32  instruction word qualified by exe_enable.
trace_enable  input  1  capture gate; when low, exe_enable is ignored.
clear_in  input  1  synchronous clear of overflow_flag and drop_count.
out_data  output  8  stream byte.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts the byte.
overflow_flag  output  1  sticky; set when a capture was dropped.
drop_count  output  16  number of dropped captures, saturating.
fifo_count  output  FIFO_ADDR_BITS+1  number of records currently held.

Behaviour:
Clock and reset:
- One clock: clk. Reset is asynchronous and active-high, on port reset.
- Reset values: out_data=0, out_valid=0, overflow_flag=0, drop_count=0, fifo_count=0, FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-record discards the partial record and all FIFO contents. No byte is emitted after reset until a new capture arrives.

Capture:
- Push condition: exe_enable & trace_enable & (not full, or pop in the same cycle).
- Push writes {PC_in, IR_in} at wr_ptr and increments wr_ptr modulo depth.
- Full with no pop in the same cycle: the capture is dropped, overflow_flag<=1, drop_count<=drop_count+1, saturating at 16'hFFFF.
- clear_in has priority over a simultaneous drop on overflow_flag and drop_count; both go to 0 and that drop is not counted.
- Full and empty are determined from pointers carrying one extra wrap bit. fifo_count = wr_ptr - rd_ptr, kept exact across wrap-around.

Serializer FSM (states IDLE, SYNC, PC, IR):
- IDLE: when the FIFO is not empty, pop the head into a 64-bit shift register, then set out_data=SYNC_BYTE, out_valid=1, go to SYNC.
- SYNC: on out_valid&out_ready, load PC[31:24] into out_data, byte index=0, go to PC.
- PC: bytes are sent MSB first, PC[31:24], [23:16], [15:8], [7:0]. After the 4th byte is accepted, load IR[31:24] and go to IR.
- IR: same MSB-first order. After the 4th byte is accepted:
  - if the FIFO is not empty, pop immediately, present SYNC_BYTE and go to SYNC (back-to-back records, no idle cycle);
  - otherwise out_valid<=0 and go to IDLE.
- Each record is exactly 9 bytes.

Handshake rules:
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- A byte transfers only on a cycle where out_valid=1 and out_ready=1.
- out_ready held high gives one byte per cycle.

Latency:
- Capture at edge N reaches the FIFO at N+1.
- IDLE pops at N+1, and out_valid=1 with SYNC_BYTE is visible after edge N+2.

Simultaneous push and pop:
- Allowed in every state, including full.
- fifo_count is unchanged by a simultaneous push and pop, and no drop is recorded.

Test Plan:
1. Reset, then a single exe_enable with PC=32'h8000_0000, IR=32'h0000_0013, out_ready=1 -> bytes A5,80,00,00,00,00,00,00,13 on 9 consecutive cycles, out_valid first high 2 cycles after the capture, then out_valid=0.
2. 3 captures on consecutive cycles, out_ready=1 -> 27 contiguous bytes with no out_valid gap; fifo_count peaks at 2 and returns to 0.
3. out_ready=0, then 20 captures (depth 16) -> fifo_count=16, overflow_flag=1, drop_count=3 (one record already popped into the shifter). Pulse clear_in -> flag 0, count 0.
4. out_ready toggled 1/0 each cycle with PC=32'h1234_5678 -> every byte is held stable while stalled, and the sequence received is A5,12,34,56,78 followed by the IR bytes.
5. Assert reset after the 3rd byte of a record with 2 records queued -> out_valid=0 and fifo_count=0 immediately; no bytes appear after release until a new capture.
6. FIFO full, exe_enable on the same cycle the IR state accepts its last byte -> the push is accepted, drop_count unchanged, fifo_count stays 16.

Source files
------------

// File: rtl/exe_trace_streamer.sv
// rtl/exe_trace_streamer.sv - captures retired PC/IR pairs into a FIFO and streams them as 9-byte framed records
module exe_trace_streamer #(
  parameter int          FIFO_ADDR_BITS = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      exe_enable,
  input  logic [31:0]               PC_in,
  input  logic [31:0]               IR_in,
  input  logic                      trace_enable,
  input  logic                      clear_in,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow_flag,
  output logic [15:0]               drop_count,
  output logic [FIFO_ADDR_BITS:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PC, S_IR} state_t;

  state_t                  r_state, w_state_nxt;
  logic [63:0]             r_mem [DEPTH];
  logic [FIFO_ADDR_BITS:0] r_wr_ptr, r_rd_ptr;
  logic [63:0]             r_shift, w_shift_nxt;
  logic [7:0]              r_data, w_data_nxt;
  logic                    r_valid, w_valid_nxt;
  logic [1:0]              r_idx, w_idx_nxt;
  logic                    r_ovf;
  logic [15:0]             r_drop;

  logic w_empty, w_full, w_xfer, w_pop, w_push, w_drop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_ADDR_BITS] != r_rd_ptr[FIFO_ADDR_BITS]) &&
                   (r_wr_ptr[FIFO_ADDR_BITS-1:0] == r_rd_ptr[FIFO_ADDR_BITS-1:0]);
  assign w_xfer  = r_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_push  = exe_enable & trace_enable & (~w_full | w_pop);
  assign w_drop  = exe_enable & trace_enable & w_full & ~w_pop;

  assign out_data      = r_data;
  assign out_valid     = r_valid;
  assign overflow_flag = r_ovf;
  assign drop_count    = r_drop;
  assign fifo_count    = r_wr_ptr - r_rd_ptr;

  // Record storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_ADDR_BITS-1:0]] <= {PC_in, IR_in};
  end

  // FIFO pointers and drop accounting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (clear_in) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  // Serializer state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: the shifter's top byte is always the next payload byte to present
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr[FIFO_ADDR_BITS-1:0]];
          w_data_nxt  = SYNC_BYTE;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        if (w_xfer) begin
          w_data_nxt  = r_shift[63:56];
          w_shift_nxt = r_shift << 8;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_PC;
        end
      end
      S_PC: begin
        if (w_xfer) begin
          w_data_nxt  = r_shift[63:56];
          w_shift_nxt = r_shift << 8;
          w_idx_nxt   = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_nxt = S_IR;
        end
      end
      S_IR: begin
        if (w_xfer) begin
          if (r_idx == 2'd3) begin
            w_idx_nxt = 2'd0;
            if (!w_empty) begin
              // back-to-back record: no idle cycle between frames
              w_pop       = 1'b1;
              w_shift_nxt = r_mem[r_rd_ptr[FIFO_ADDR_BITS-1:0]];
              w_data_nxt  = SYNC_BYTE;
              w_state_nxt = S_SYNC;
            end else begin
              w_valid_nxt = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_data_nxt  = r_shift[63:56];
            w_shift_nxt = r_shift << 8;
            w_idx_nxt   = r_idx + 2'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exe_trace_streamer.sv
// tb/tb_exe_trace_streamer.sv - randomized and directed checks of exe_trace_streamer against a record-level model
module tb_exe_trace_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exe_enable = 1'b0;
  logic [31:0] PC_in = '0;
  logic [31:0] IR_in = '0;
  logic        trace_enable = 1'b1;
  logic        clear_in = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow_flag;
  logic [15:0] drop_count;
  logic [4:0]  fifo_count;

  exe_trace_streamer #(.FIFO_ADDR_BITS(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .exe_enable(exe_enable), .PC_in(PC_in), .IR_in(IR_in),
    .trace_enable(trace_enable), .clear_in(clear_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .overflow_flag(overflow_flag),
    .drop_count(drop_count), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model: queue of pending records plus bytes remaining in the one on the wire
  logic [63:0] mq[$];
  logic [63:0] mcur = '0;
  int          mrem = 0;
  int          mdrop = 0;
  bit          movf = 1'b0;
  logic [7:0]  rx[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rec_byte(input logic [63:0] r, input int k);
    if (k == 0) return 8'hA5;
    return r[63 - 8*(k-1) -: 8];
  endfunction

  task automatic model_reset();
    mq.delete();
    mrem  = 0;
    mdrop = 0;
    movf  = 1'b0;
  endtask

  task automatic model_edge();
    bit xfer, pop, full, acc, drp;
    if (reset) begin
      model_reset();
      return;
    end
    xfer = (mrem > 0) && out_ready;
    pop  = (mq.size() > 0) && ((mrem == 0) || (mrem == 1 && xfer));
    full = (mq.size() == 16);
    acc  = exe_enable && trace_enable && (!full || pop);
    drp  = exe_enable && trace_enable && full && !pop;
    if (pop) begin
      mcur = mq.pop_front();
      mrem = 9;
    end else if (xfer) begin
      mrem--;
    end
    if (acc) mq.push_back({PC_in, IR_in});
    if (clear_in) begin
      movf  = 1'b0;
      mdrop = 0;
    end else if (drp) begin
      movf = 1'b1;
      if (mdrop < 65535) mdrop++;
    end
  endtask

  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(mrem > 0));
    if (mrem > 0) chk("out_data", 64'(out_data), 64'(rec_byte(mcur, 9 - mrem)));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("overflow_flag", 64'(overflow_flag), 64'(movf));
    chk("drop_count", 64'(drop_count), 64'(mdrop));
  endtask

  task automatic step(input bit en, input bit tr, input bit clr, input bit rdy,
                      input logic [31:0] pc, input logic [31:0] ir);
    exe_enable   = en;
    trace_enable = tr;
    clear_in     = clr;
    out_ready    = rdy;
    PC_in        = pc;
    IR_in        = ir;
    if (out_valid && rdy) rx.push_back(out_data);
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b1, 1'b0, rdy, $urandom, $urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((mrem != 0 || mq.size() != 0) && n < 400) begin
      idle(1'b1);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [7:0] exp1 [9];
    logic [7:0] exp4 [5];
    int peak;
    int n;
    logic [15:0] drop_before;

    exp1 = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h13};
    exp4 = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78};

    // Reset state
    model_reset();
    idle(1'b1);
    idle(1'b1);
    reset = 1'b0;
    idle(1'b1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // 1: single record, latency and byte order
    rx.delete();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0013);
    chk("t1_valid_lat1", 64'(out_valid), 64'd0);
    idle(1'b1);
    chk("t1_valid_lat2", 64'(out_valid), 64'd1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    chk("t1_valid_end", 64'(out_valid), 64'd0);
    chk("t1_nbytes", 64'(rx.size()), 64'd9);
    for (int i = 0; i < 9 && i < rx.size(); i++) chk("t1_byte", 64'(rx[i]), 64'(exp1[i]));

    // 2: three back-to-back captures
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
      if (fifo_count > peak) peak = fifo_count;
    end
    for (int i = 0; i < 30; i++) begin
      idle(1'b1);
      if (fifo_count > peak) peak = fifo_count;
    end
    chk("t2_peak", 64'(peak), 64'd2);
    drain();

    // 3: overflow with stalled consumer, then clear
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom);
    chk("t3_fifo_full", 64'(fifo_count), 64'd16);
    chk("t3_ovf", 64'(overflow_flag), 64'd1);
    chk("t3_drop", 64'(drop_count), 64'd3);
    step(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom);
    chk("t3_clr_ovf", 64'(overflow_flag), 64'd0);
    chk("t3_clr_drop", 64'(drop_count), 64'd0);

    // 6: push while full on the cycle the last IR byte is accepted
    n = 0;
    while (mrem != 1 && n < 20) begin
      idle(1'b1);
      n++;
    end
    if (n >= 20) chk("t6_timeout", 64'd1, 64'd0);
    drop_before = drop_count;
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
    chk("t6_fifo", 64'(fifo_count), 64'd16);
    chk("t6_drop", 64'(drop_count), 64'(drop_before));
    drain();

    // 4: consumer toggling ready
    rx.delete();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5678, $urandom);
    for (int i = 0; i < 24; i++) idle(i[0]);
    drain();
    chk("t4_nbytes", 64'(rx.size()), 64'd9);
    for (int i = 0; i < 5 && i < rx.size(); i++) chk("t4_byte", 64'(rx[i]), 64'(exp4[i]));

    // 5: reset mid-record with two records queued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
    n = 0;
    while (mrem != 6 && n < 20) begin
      idle(1'b1);
      n++;
    end
    if (n >= 20) chk("t5_timeout", 64'd1, 64'd0);
    chk("t5_queued", 64'(fifo_count), 64'd2);
    reset = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_fifo", 64'(fifo_count), 64'd0);
    idle(1'b1);
    reset = 1'b0;
    rx.delete();
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("t5_no_bytes", 64'(rx.size()), 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
    drain();
    chk("t5_new_record", 64'(rx.size()), 64'd9);

    // Randomized traffic: slow consumer first to provoke drops, then a fast one
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0,
           (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom, $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
